// File: rtl/blink_pkg.sv
// blink_pkg: shared state type and width macro for the blink monitor
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
package blink_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, STALLED} blink_state_t;
endpackage

// File: rtl/blink_sync.sv
// blink_sync: synchronizes the asynchronous blink input and flags each transition
//   clk, rst_n : clock, synchronous active-low reset
//   d          : asynchronous blink input
//   d_edge     : high for one cycle after the synchronized level changes
module blink_sync #(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic d_edge
);
  logic [sync_stages-1:0] sync_q;
  logic d_s, d_prev;
  assign d_s = sync_q[sync_stages-1];
  assign d_edge = d_s ^ d_prev;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync_q <= '0;
      d_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], d};
      d_prev <= d_s;
    end
endmodule

// File: rtl/blink_monitor.sv
// blink_monitor: measures blink half-periods, declares lock, flags mismatches and stalls
//   clk, rst_n    : clock, synchronous active-low reset
//   d             : asynchronous blink input
//   period        : last measured half-period in clk cycles
//   period_valid  : one-cycle pulse when period updates
//   locked        : half-periods are within tolerance
//   stalled       : no transition for a full period
//   err           : one-cycle pulse when a locked input goes out of tolerance
//   edge_count, err_count : present only with BLINK_MONITOR_STATS_EN defined
module blink_monitor
  import blink_pkg::*;
#(
  parameter int clk_freq_hz = 1_000_000_000,
  parameter int tol_cycles  = 1,
  parameter int sync_stages = 2,
  localparam int W = `CLOG2(2 * clk_freq_hz + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         stalled,
  output logic         err
`ifdef BLINK_MONITOR_STATS_EN
  ,
  output logic [31:0]  edge_count,
  output logic [15:0]  err_count
`endif
);
  localparam logic [W-1:0] T  = W'(2 * clk_freq_hz);
  localparam logic [W-1:0] LO = W'(clk_freq_hz - tol_cycles);
  localparam logic [W-1:0] HI = W'(clk_freq_hz + tol_cycles);
  logic [W-1:0] cnt, h;
  logic d_edge, timeout, good, measuring, report, err_n;
  blink_state_t state, state_n;
  blink_sync #(.sync_stages(sync_stages)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .d_edge (d_edge)
  );
  assign h = cnt + W'(1);
  assign good = h >= LO && h <= HI;
  // an edge in the last cycle of the window counts as a measurement, not a stall
  assign timeout = !d_edge && cnt == T - W'(1);
  assign measuring = state == ACQUIRE || state == LOCKED;
  assign locked = state == LOCKED;
  assign stalled = state == STALLED;
  always_comb begin
    report = d_edge && measuring;
    err_n = report && state == LOCKED && !good;
    state_n = d_edge ? (report && good ? LOCKED : ACQUIRE)
            : (timeout && measuring) ? STALLED : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= d_edge ? '0 : cnt == T ? T : h;
      period_valid <= report;
      err <= err_n;
      if (report) period <= h;
    end
`ifdef BLINK_MONITOR_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      edge_count <= '0;
      err_count <= '0;
    end else begin
      edge_count <= edge_count + 32'(d_edge);
      err_count <= err_count + 16'(err_n && err_count != 16'hFFFF);
    end
`endif
endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed table-driven check of blink_monitor at clk_freq_hz=10
module tb_blink_monitor;
  localparam int W = $clog2(21);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d = 1'b0;
  logic [W-1:0] period;
  logic period_valid, locked, stalled, err;
`ifdef BLINK_MONITOR_STATS_EN
  logic [31:0] edge_count;
  logic [15:0] err_count;
`endif
  int tests = 0;
  int fails = 0;
  int since = 0;
  typedef struct {
    int   gap;
    logic pv;
    int   per;
    logic er;
    logic lk;
    logic st;
  } vec_t;
  vec_t vecs[13];
  blink_monitor #(.clk_freq_hz(10), .tol_cycles(1), .sync_stages(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d            (d),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .stalled      (stalled),
    .err          (err)
`ifdef BLINK_MONITOR_STATS_EN
    ,
    .edge_count   (edge_count),
    .err_count    (err_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
    since++;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_stats(input string name, input int ec, input int erc);
`ifdef BLINK_MONITOR_STATS_EN
    chk({name, " edge_count"}, edge_count, ec);
    chk({name, " err_count"}, 32'(err_count), erc);
`else
    if (ec < 0 || erc < 0) $display("bad stats expectation in %s", name);
`endif
  endtask
  task automatic do_edge(input string name, input vec_t v);
    repeat (v.gap - since) tick();
    d = ~d;
    since = 0;
    repeat (3) tick();
    chk({name, " period_valid"}, 32'(period_valid), 32'(v.pv));
    chk({name, " period"}, 32'(period), v.per);
    chk({name, " err"}, 32'(err), 32'(v.er));
    chk({name, " locked"}, 32'(locked), 32'(v.lk));
    chk({name, " stalled"}, 32'(stalled), 32'(v.st));
    tick();
    chk({name, " pulse_end"}, 32'({period_valid, err}), 0);
  endtask
  initial begin
    vecs[0]  = '{10, 1'b0,  0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{13, 1'b1, 13, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{ 9, 1'b1,  9, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{11, 1'b1, 11, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{ 8, 1'b1,  8, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{12, 1'b1, 12, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{12, 1'b1, 12, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{20, 1'b1, 20, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset outputs", {27'(period), period_valid, locked, stalled, err}, 0);
    rst_n = 1'b1;
    since = 0;
    repeat (5) tick();
    chk("idle outputs", {27'(period), period_valid, locked, stalled, err}, 0);
    chk_stats("idle", 0, 0);
    for (int i = 0; i < 13; i++) do_edge($sformatf("vec%0d", i), vecs[i]);
    repeat (22 - since) tick();
    chk("stall early", 32'(stalled), 0);
    tick();
    chk("stall stalled", 32'(stalled), 1);
    chk("stall err", 32'(err), 0);
    chk("stall locked", 32'(locked), 0);
    do_edge("stall exit", '{30, 1'b0, 10, 1'b0, 1'b0, 1'b0});
    do_edge("relock", '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0});
    chk_stats("before reset", 15, 4);
    rst_n = 1'b0;
    tick();
    chk("mid reset outputs", {27'(period), period_valid, locked, stalled, err}, 0);
    chk_stats("mid reset", 0, 0);
    rst_n = 1'b1;
    since = 0;
    repeat (3) tick();
    chk("release edge state", {27'(period), period_valid, locked, stalled, err}, 0);
    chk_stats("release edge", 1, 0);
    do_edge("after reset", '{10, 1'b1, 10, 1'b0, 1'b1, 1'b0});
    chk_stats("after reset", 2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
